// File: rtl/instr_stream_router.sv
// rtl/instr_stream_router.sv - splits a header+payload instruction stream into bank-tagged words behind a 1-deep output register
// Optional bad-bank detection with a DROP state is enabled by defining INSTR_ROUTER_BANK_CHECK_EN.
module instr_stream_router #(
  parameter int STREAM_WIDTH = 128,
  parameter int NUM_BANKS    = 4,
  parameter int LEN_WIDTH    = 8,
  localparam int BANK_W      = $clog2(NUM_BANKS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STREAM_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [STREAM_WIDTH-1:0] m_data,
  output logic                    m_valid,
  output logic [BANK_W-1:0]       m_bank,
  input  logic                    m_ready,
  output logic                    pkt_done,
  output logic                    err_bank
);

`ifdef INSTR_ROUTER_BANK_CHECK_EN
  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
`else
  typedef enum logic [1:0] {HDR, PAYLOAD} state_t;
`endif

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
  logic [STREAM_WIDTH-1:0] m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic [BANK_W-1:0]       m_bank_q, m_bank_d;
  logic                    pkt_done_q, pkt_done_d;
  logic                    err_bank_q, err_bank_d;

  logic [LEN_WIDTH-1:0]    hdr_len;
  logic [BANK_W-1:0]       hdr_bank;
  logic                    hdr_bad;
  logic                    accept;
  logic                    last_word;
  logic [LEN_WIDTH-1:0]    remaining_dec;

  assign hdr_len  = s_data[8 +: LEN_WIDTH];
  assign hdr_bank = s_data[BANK_W-1:0];

`ifdef INSTR_ROUTER_BANK_CHECK_EN
  assign hdr_bad = ({24'd0, s_data[7:0]} >= 32'(NUM_BANKS));
`else
  assign hdr_bad = 1'b0;
`endif

  assign accept        = s_valid && s_ready;
  assign last_word     = (remaining_q == LEN_WIDTH'(1));
  // Saturating decrement: the count never wraps below zero.
  assign remaining_dec = (remaining_q != '0) ? remaining_q - LEN_WIDTH'(1) : '0;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_bank_d    = m_bank_q;
    pkt_done_d  = 1'b0;
    err_bank_d  = err_bank_q;
    s_ready     = !m_valid_q || m_ready;

    // Drain first; a same-cycle accept below re-asserts valid with the new word.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      HDR: begin
        if (accept) begin
          remaining_d = hdr_len;
          if (hdr_bad) begin
            err_bank_d = 1'b1;
          end else begin
            m_bank_d = hdr_bank;
          end
          if (hdr_len == '0) begin
            pkt_done_d = 1'b1;
          end else begin
`ifdef INSTR_ROUTER_BANK_CHECK_EN
            state_d = hdr_bad ? DROP : PAYLOAD;
`else
            state_d = PAYLOAD;
`endif
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          m_data_d    = s_data;
          m_valid_d   = 1'b1;
          remaining_d = remaining_dec;
          if (last_word) begin
            state_d    = HDR;
            pkt_done_d = 1'b1;
          end
        end
      end

`ifdef INSTR_ROUTER_BANK_CHECK_EN
      DROP: begin
        s_ready = 1'b1;
        if (accept) begin
          remaining_d = remaining_dec;
          if (last_word) begin
            state_d    = HDR;
            pkt_done_d = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = HDR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HDR;
      remaining_q <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_bank_q    <= '0;
      pkt_done_q  <= 1'b0;
      err_bank_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_bank_q    <= m_bank_d;
      pkt_done_q  <= pkt_done_d;
      err_bank_q  <= err_bank_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_bank   = m_bank_q;
  assign pkt_done = pkt_done_q;
  assign err_bank = err_bank_q;

endmodule
